// File: rtl/audio_frame_keygen.sv
// Frames the raw audio sample stream into aligned FRAME_LEN-sample frames and
// attaches a per-frame LFSR shift key and a periodic sync-frame marker.
module audio_frame_keygen #(
  parameter int          FRAME_LEN   = 64,
  parameter int          SYNC_PERIOD = 16,
  parameter logic [23:0] SEED        = 24'hACE1F0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] in_real,
  input  logic        start,
  input  logic        stop,
  input  logic        scramble_on,
  input  logic        seed_load,
  input  logic [23:0] seed,
  output logic        di_en,
  output logic [15:0] out_real,
  output logic [23:0] shift_key,
  output logic        frame_start,
  output logic        sync_frame,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Handshake: in_en is a valid-only strobe with no backpressure. Every in_en
  // seen in RUN or DRAIN yields exactly one di_en one cycle later carrying the
  // same sample; in_en in IDLE is dropped.

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int FW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(SYNC_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] sample_cnt, sample_cnt_next;
  logic [FW-1:0] frame_cnt, frame_cnt_next;
  logic [23:0]   lfsr, lfsr_next, lfsr_step;

  logic          di_en_next;
  logic [15:0]   out_real_next;
  logic [23:0]   shift_key_next;
  logic          frame_start_next;
  logic          sync_frame_next;

  logic          active;
  logic          accept;
  logic          first_sample;
  logic          last_sample;

  assign active       = (state == RUN) || (state == DRAIN);
  assign accept       = active && in_en;
  assign first_sample = accept && (sample_cnt == '0);
  assign last_sample  = accept && (sample_cnt == SAMPLE_LAST);
  // Taps 24,23,22,17: maximal length, so a non-zero seed never reaches zero.
  assign lfsr_step    = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};

  assign busy      = active;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        // Stop on an untouched frame boundary ends at once; otherwise the
        // current frame is completed in DRAIN.
        if (stop) begin
          if (last_sample || (!in_en && sample_cnt == '0)) state_next = IDLE;
          else                                             state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_sample) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sample_cnt_next  = sample_cnt;
    frame_cnt_next   = frame_cnt;
    lfsr_next        = lfsr;
    di_en_next       = accept;
    out_real_next    = accept ? in_real : out_real;
    frame_start_next = first_sample;
    shift_key_next   = shift_key;
    sync_frame_next  = sync_frame;

    if (state == IDLE) begin
      shift_key_next  = 24'b0;
      sync_frame_next = 1'b0;
      if (start) begin
        sample_cnt_next = '0;
        frame_cnt_next  = '0;
      end else if (seed_load) begin
        lfsr_next = (seed == 24'b0) ? SEED : seed;
      end
    end else if (accept) begin
      if (first_sample) begin
        shift_key_next  = scramble_on ? lfsr : 24'b0;
        sync_frame_next = (frame_cnt == '0);
      end
      if (last_sample) begin
        sample_cnt_next = '0;
        frame_cnt_next  = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
        lfsr_next       = lfsr_step;
      end else begin
        sample_cnt_next = sample_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_cnt  <= '0;
      frame_cnt   <= '0;
      lfsr        <= SEED;
      di_en       <= 1'b0;
      out_real    <= 16'b0;
      shift_key   <= 24'b0;
      frame_start <= 1'b0;
      sync_frame  <= 1'b0;
    end else begin
      sample_cnt  <= sample_cnt_next;
      frame_cnt   <= frame_cnt_next;
      lfsr        <= lfsr_next;
      di_en       <= di_en_next;
      out_real    <= out_real_next;
      shift_key   <= shift_key_next;
      frame_start <= frame_start_next;
      sync_frame  <= sync_frame_next;
    end
  end

endmodule
